// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory side and decode side.
// The fetch stage takes the master view, the environment the slave view.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            trigger;
  logic            StallD;
  logic            FlushD;
  logic            PCSrcD;
  logic [XLEN-1:0] PCBranchD;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            ValidD;
  logic            Fetching;

  modport master (
    input  trigger,
    input  StallD,
    input  FlushD,
    input  PCSrcD,
    input  PCBranchD,
    input  imem_ready,
    input  imem_rdata,
    output imem_addr,
    output InstrD,
    output PCD,
    output PCPlus4D,
    output ValidD,
    output Fetching
  );

  modport slave (
    output trigger,
    output StallD,
    output FlushD,
    output PCSrcD,
    output PCBranchD,
    output imem_ready,
    output imem_rdata,
    input  imem_addr,
    input  InstrD,
    input  PCD,
    input  PCPlus4D,
    input  ValidD,
    input  Fetching
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage with a DEPTH-entry queue
// decoupling the PC from decode stalls and memory wait states.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
  input logic           clk,
  input logic           reset,
  fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic valid;
  logic fetching;
  logic full;
  logic pop;
  logic push;
  logic unused_lsb;

  assign valid    = count != '0;
  assign fetching = state == RUN;
  assign full     = count == CW'(DEPTH);
  assign pop      = valid
                  && (!bus.StallD || bus.FlushD);
  assign push     = fetching
                  && bus.imem_ready
                  && !bus.PCSrcD
                  && (!full || pop);

  // Target low bits are dropped: fetch is word aligned.
  assign unused_lsb = ^bus.PCBranchD[1:0];

  // Start control: wait for trigger, then run until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else if (state == IDLE && bus.trigger) begin
      state <= RUN;
    end
  end

  // PC, occupancy and pointers; redirect overrides push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.PCSrcD) begin
      pc     <= {bus.PCBranchD[XLEN-1:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        pc     <= pc + XLEN'(4);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Queue storage: fetched word and its PC at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= bus.imem_rdata;
      pc_mem[wr_ptr]    <= pc;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.ValidD    = valid;
  assign bus.Fetching  = fetching;
  assign bus.InstrD    = valid ? instr_mem[rd_ptr] : NOP;
  assign bus.PCD       = valid ? pc_mem[rd_ptr] : '0;
  assign bus.PCPlus4D  = valid ? pc_mem[rd_ptr] + XLEN'(4)
                               : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(
    .XLEN    (32),
    .DEPTH   (4),
    .RESET_PC(32'h0),
    .NOP     (NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    return (a << 4) ^ 32'h1234_5673;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mpc  = 32'h0;
  bit          mrun = 1'b0;
  bit          mpop;
  bit          mpush;

  // Reference model: a FIFO of {word, pc} advanced each edge.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      mpc  = 32'h0;
      mrun = 1'b0;
    end else begin
      if (bus.PCSrcD) begin
        mq.delete();
        mpc = {bus.PCBranchD[31:2], 2'b00};
      end else begin
        mpop  = mq.size() > 0
             && (!bus.StallD || bus.FlushD);
        mpush = mrun && bus.imem_ready
             && (mq.size() < 4 || mpop);
        if (mpop) void'(mq.pop_front());
        if (mpush) begin
          mq.push_back({mem_word(mpc), mpc});
          mpc = mpc + 32'd4;
        end
      end
      if (!mrun && bus.trigger) mrun = 1'b1;
    end
  end

  // Compare process: DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      chk("m_valid", 32'(bus.ValidD),
          32'(mq.size() != 0));
      chk("m_fetching", 32'(bus.Fetching), 32'(mrun));
      chk("m_addr", bus.imem_addr, mpc);
      if (mq.size() != 0) begin
        chk("m_instr", bus.InstrD, mq[0].instr);
        chk("m_pcd", bus.PCD, mq[0].pc);
        chk("m_pc4", bus.PCPlus4D, mq[0].pc + 32'd4);
      end else begin
        chk("m_instr", bus.InstrD, NOP);
        chk("m_pcd", bus.PCD, 32'h0);
        chk("m_pc4", bus.PCPlus4D, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.trigger    = 1'b0;
    bus.StallD     = 1'b0;
    bus.FlushD     = 1'b0;
    bus.PCSrcD     = 1'b0;
    bus.PCBranchD  = 32'h0;
    bus.imem_ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.ValidD), 32'h0);
    chk("rst_instr", bus.InstrD, NOP);
    chk("rst_pcd", bus.PCD, 32'h0);
    chk("rst_pc4", bus.PCPlus4D, 32'h0);
    chk("rst_fetch", 32'(bus.Fetching), 32'h0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    #1;
    reset = 1'b0;
  endtask

  task automatic start(input logic stall);
    do_reset();
    bus.StallD     = stall;
    bus.imem_ready = 1'b1;
    bus.trigger    = 1'b1;
    tick();
    bus.trigger    = 1'b0;
  endtask

  initial begin
    bus.trigger    = 1'b0;
    bus.StallD     = 1'b0;
    bus.FlushD     = 1'b0;
    bus.PCSrcD     = 1'b0;
    bus.PCBranchD  = 32'h0;
    bus.imem_ready = 1'b0;
    #1;

    // Reset and start
    start(1'b0);
    chk("t1_fetch", 32'(bus.Fetching), 32'h1);
    chk("t1_empty", 32'(bus.ValidD), 32'h0);
    chk("t1_nop", bus.InstrD, NOP);
    tick();
    chk("t1_valid", 32'(bus.ValidD), 32'h1);
    chk("t1_instr0", bus.InstrD, 32'h1234_5673);
    for (int i = 0; i < 4; i++) begin
      chk("t1_pcd", bus.PCD, 32'(4 * i));
      chk("t1_pc4", bus.PCPlus4D, 32'(4 * i + 4));
      tick();
    end

    // Stall fill, then drain in order
    start(1'b1);
    repeat (7) tick();
    chk("t2_addr", bus.imem_addr, 32'd16);
    chk("t2_head", bus.PCD, 32'd0);
    bus.StallD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_order", bus.PCD, 32'(4 * i));
      tick();
    end

    // Redirect with three entries queued
    start(1'b1);
    repeat (3) tick();
    bus.PCSrcD    = 1'b1;
    bus.PCBranchD = 32'h100;
    tick();
    bus.PCSrcD = 1'b0;
    chk("t3_valid", 32'(bus.ValidD), 32'h0);
    chk("t3_addr", bus.imem_addr, 32'h100);
    tick();
    chk("t3_pcd", bus.PCD, 32'h100);
    chk("t3_instr", bus.InstrD, 32'h1234_4673);
    bus.PCSrcD    = 1'b1;
    bus.PCBranchD = 32'h102;
    tick();
    bus.PCSrcD = 1'b0;
    chk("t3_align", bus.imem_addr, 32'h100);
    chk("t3_valid2", 32'(bus.ValidD), 32'h0);
    tick();
    chk("t3_pcd2", bus.PCD, 32'h100);

    // Memory wait states 1,0,0,1
    start(1'b0);
    tick();
    bus.imem_ready = 1'b0;
    chk("t4_pcd0", bus.PCD, 32'h0);
    tick();
    chk("t4_gap", 32'(bus.ValidD), 32'h0);
    chk("t4_hold", bus.imem_addr, 32'h4);
    tick();
    bus.imem_ready = 1'b1;
    chk("t4_gap2", 32'(bus.ValidD), 32'h0);
    tick();
    chk("t4_pcd4", bus.PCD, 32'h4);

    // Flush under stall with two entries
    start(1'b1);
    repeat (2) tick();
    bus.imem_ready = 1'b0;
    bus.FlushD     = 1'b1;
    tick();
    bus.FlushD = 1'b0;
    chk("t5_head", bus.PCD, 32'h4);
    bus.StallD = 1'b0;
    tick();
    chk("t5_one", 32'(bus.ValidD), 32'h0);

    // Full queue with pop and push together
    start(1'b1);
    repeat (4) tick();
    bus.StallD = 1'b0;
    tick();
    bus.StallD     = 1'b1;
    bus.imem_ready = 1'b0;
    chk("t5_addr", bus.imem_addr, 32'd20);
    bus.FlushD = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_full", bus.PCD, 32'(4 + 4 * i));
      tick();
    end
    bus.FlushD = 1'b0;
    chk("t5_drained", 32'(bus.ValidD), 32'h0);

    // PC wrap, then async reset mid-run
    start(1'b0);
    bus.PCSrcD    = 1'b1;
    bus.PCBranchD = 32'hFFFF_FFFC;
    tick();
    bus.PCSrcD = 1'b0;
    chk("t6_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_wrap", bus.imem_addr, 32'h0);
    chk("t6_pcd", bus.PCD, 32'hFFFF_FFFC);
    chk("t6_pc4", bus.PCPlus4D, 32'h0);
    do_reset();
    bus.imem_ready = 1'b1;
    bus.PCSrcD     = 1'b1;
    bus.PCBranchD  = 32'h40;
    tick();
    bus.PCSrcD = 1'b0;
    chk("t6_idle_rd", bus.imem_addr, 32'h40);
    repeat (3) tick();
    chk("t6_held", 32'(bus.Fetching), 32'h0);
    chk("t6_noval", 32'(bus.ValidD), 32'h0);
    bus.trigger = 1'b1;
    tick();
    bus.trigger = 1'b0;
    chk("t6_resume", 32'(bus.Fetching), 32'h1);
    tick();
    chk("t6_first", bus.PCD, 32'h40);
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch stage with a decoupling instruction queue between the program counter and the decode stage. It is the successor to the single-register fetch stage:
- instruction memory may insert wait states (`imem_ready`);
- decode stalls are absorbed by a `DEPTH`-entry FIFO instead of freezing the PC;
- `trigger` gates the start of execution after reset.

It sits between the instruction ROM and the decode stage and receives redirects from the branch unit in decode.

## Interface
- `XLEN`, default 32: address and instruction width.
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.
- `NOP`, default 32'h0000_0013: value driven on `InstrD` when the queue is empty.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `trigger`  in  1  start pulse; sampled only in IDLE.
- `StallD`  in  1  decode not accepting the head entry this cycle.
- `FlushD`  in  1  discard the head entry (bubble into decode).
- `PCSrcD`  in  1  redirect request from decode.
- `PCBranchD`  in  XLEN  redirect target.
- `imem_ready`  in  1  `imem_rdata` is valid for `imem_addr` this cycle.
- `imem_rdata`  in  XLEN  instruction word from memory (combinational read).
- `imem_addr`  out  XLEN  current fetch PC.
- `InstrD`  out  XLEN  head instruction, or `NOP` when the queue is empty.
- `PCD`  out  XLEN  PC of the head instruction; 0 when empty.
- `PCPlus4D`  out  XLEN  `PCD + 4`; 0 when empty.
- `ValidD`  out  1  queue non-empty.
- `Fetching`  out  1  state is RUN.

## Operation
States:
- **IDLE** (reset state): no fetch.
  - `trigger=1` moves to RUN on the next edge.
- **RUN**: fetching.
  - Stays in RUN until reset.
  - `trigger` is ignored.

Datapath:
- `imem_addr` = PC register in every state.
- **Push** (fetch fire): `Fetching && imem_ready && !PCSrcD && (count<DEPTH || pop)`.
  - Writes {`imem_rdata`, PC} at the tail.
  - PC <= PC+4, modulo 2^XLEN (wrap-around, no error).
- **Pop**: `ValidD && (!StallD || FlushD)`.
  - Removes the head entry.
  - `FlushD` pops the head regardless of `StallD`.
  - `FlushD` with an empty queue has no effect.
- **Redirect**: `PCSrcD=1`, honoured in IDLE and RUN.
  - Has priority over push and pop.
  - Queue cleared (count <= 0, pointers reset).
  - PC <= {`PCBranchD[XLEN-1:2]`, 2'b00}.
  - Redirect in IDLE updates the PC but does not start fetching.
- **Full and pop together**: push permitted in the same cycle; count unchanged.
- **Empty and push together**: the entry becomes visible the next cycle. There is no bypass; outputs come from storage only.
- Count register width is clog2(DEPTH+1).
- Head outputs come directly from the queue storage and read pointer. No additional output register.

## Timing
Reset, asynchronous and immediate:
- state=IDLE, PC=`RESET_PC`, count=0, pointers=0.
- `ValidD`=0, `InstrD`=`NOP`, `PCD`=0, `PCPlus4D`=0, `Fetching`=0, `imem_addr`=`RESET_PC`.

Start-up, with `imem_ready=1`:
- `trigger` high in cycle 0 → RUN in cycle 1.
- First push at the end of cycle 1.
- `ValidD=1` with `PCD=RESET_PC` in cycle 2.

Throughput:
- Steady state is one push and one pop per cycle.
- Fetch-to-decode latency is 1 cycle.

Redirect:
- `PCSrcD` in cycle n → `ValidD=0` and `imem_addr=PCBranchD` in cycle n+1.
- Target instruction valid in cycle n+2, given `imem_ready`.

Stall and wait states:
- With `StallD` held, the queue fills after DEPTH pushes.
- Fetch then halts and PC holds the address of the first unfetched instruction.
- `imem_ready=0` inserts a bubble without changing PC.

Reset mid-operation discards all queue contents and returns to IDLE at once. A fresh `trigger` is required to resume.

## Test plan
1. **Reset and start**
   - Stimulus: reset, then `trigger` pulse, `imem_ready=1`, DEPTH=4.
   - Required: `ValidD` rises 2 cycles after `trigger`; `PCD` sequence 0, 4, 8, 12; `PCPlus4D`=`PCD+4`; `InstrD`=`NOP` before the first push.
2. **Stall fill**
   - Stimulus: `StallD=1` for 8 cycles, then released.
   - Required: count saturates at 4; `imem_addr` freezes at 16; after release, entries 0, 4, 8, 12, 16 are delivered in order, none lost or duplicated.
3. **Redirect**
   - Stimulus: `PCSrcD=1` with `PCBranchD=0x100` while the queue holds 3 entries and `StallD=1`.
   - Required: next cycle `ValidD=0`, `imem_addr=0x100`; following cycle `PCD=0x100`.
   - Variant: repeat with `PCBranchD=0x102`; PC must be forced to 0x100.
4. **Memory wait states**
   - Stimulus: `imem_ready` toggling 1, 0, 0, 1.
   - Required: pushes only on ready cycles; `PCD` stream stays contiguous (0, 4) with `ValidD` gaps.
5. **Flush and full/pop**
   - `FlushD=1` with `StallD=1` and 2 entries queued: head dropped, count becomes 1.
   - Queue full with a simultaneous pop and push: count stays at 4 and ordering is preserved.
6. **Wrap and async reset**
   - Redirect to 0xFFFF_FFFC: the next PC wraps to 0x0.
   - Assert `reset` mid-RUN between clock edges: outputs return to reset values immediately, and fetch is held until a new `trigger`.
